// File: rtl/exec_ctrl_pkg.sv
// Shared encodings for the multicycle execute controller: ALU ops, FSM states,
// MIPS opcode/funct constants and ALU operand-select codes.
package exec_ctrl_pkg;

  typedef enum logic [4:0] {
    AluAnd  = 5'b00000,
    AluOr   = 5'b00001,
    AluAdd  = 5'b00010,
    AluXor  = 5'b00011,
    AluSll  = 5'b00100,
    AluSrl  = 5'b00101,
    AluSub  = 5'b00110,
    AluSlt  = 5'b00111,
    AluSra  = 5'b01000,
    AluSltu = 5'b01001,
    AluEq   = 5'b01010,
    AluLtz  = 5'b01100,
    AluLez  = 5'b10000
  } alu_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StExec,
    StWb,
    StBrCmp,
    StBrTgt,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    ClsIllegal = 2'b00,
    ClsAluR    = 2'b01,
    ClsAluI    = 2'b10,
    ClsBranch  = 2'b11
  } instr_class_e;

  typedef enum logic [1:0] {
    SrcaRs    = 2'b00,
    SrcaPc    = 2'b01,
    SrcaShamt = 2'b10,
    SrcaRsLow = 2'b11
  } srca_sel_e;

  typedef enum logic [1:0] {
    SrcbRt       = 2'b00,
    SrcbImmSext  = 2'b01,
    SrcbImmZext  = 2'b10,
    SrcbImmSext2 = 2'b11
  } srcb_sel_e;

  // Major opcodes
  localparam logic [5:0] OpRtype  = 6'h00;
  localparam logic [5:0] OpRegimm = 6'h01;
  localparam logic [5:0] OpBeq    = 6'h04;
  localparam logic [5:0] OpBne    = 6'h05;
  localparam logic [5:0] OpBlez   = 6'h06;
  localparam logic [5:0] OpBgtz   = 6'h07;
  localparam logic [5:0] OpAddiu  = 6'h09;
  localparam logic [5:0] OpSlti   = 6'h0A;
  localparam logic [5:0] OpSltiu  = 6'h0B;
  localparam logic [5:0] OpAndi   = 6'h0C;
  localparam logic [5:0] OpOri    = 6'h0D;
  localparam logic [5:0] OpXori   = 6'h0E;

  // R-type funct codes
  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnSra  = 6'h03;
  localparam logic [5:0] FnSllv = 6'h04;
  localparam logic [5:0] FnSrlv = 6'h06;
  localparam logic [5:0] FnSrav = 6'h07;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnXor  = 6'h26;
  localparam logic [5:0] FnSlt  = 6'h2A;
  localparam logic [5:0] FnSltu = 6'h2B;

  // REGIMM rt field selectors
  localparam logic [4:0] RtBltz = 5'd0;
  localparam logic [4:0] RtBgez = 5'd1;

endpackage

// File: rtl/exec_decode.sv
// Combinational instruction classifier: maps the instruction register onto an
// execution class, ALU op, operand selects, destination choice and branch sense.
module exec_decode
  import exec_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output logic [1:0]  cls,
  output logic [4:0]  op,
  output logic [1:0]  srca,
  output logic [1:0]  srcb,
  output logic        reg_dst,
  output logic        br_invert
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;

  assign opcode = ir[31:26];
  assign funct  = ir[5:0];
  assign rt     = ir[20:16];

  // rs, rd, shamt and immediate feed the datapath, not the controller
  logic unused_ir;
  assign unused_ir = ^{ir[25:21], ir[15:6]};

  instr_class_e cls_e;
  alu_op_e      op_e;
  srca_sel_e    srca_e;
  srcb_sel_e    srcb_e;

  always_comb begin
    cls_e     = ClsIllegal;
    op_e      = AluAnd;
    srca_e    = SrcaRs;
    srcb_e    = SrcbRt;
    br_invert = 1'b0;

    case (opcode)
      OpRtype: begin
        cls_e = ClsAluR;
        case (funct)
          FnAddu: op_e = AluAdd;
          FnSubu: op_e = AluSub;
          FnAnd:  op_e = AluAnd;
          FnOr:   op_e = AluOr;
          FnXor:  op_e = AluXor;
          FnSlt:  op_e = AluSlt;
          FnSltu: op_e = AluSltu;
          FnSll:  begin op_e = AluSll; srca_e = SrcaShamt; end
          FnSrl:  begin op_e = AluSrl; srca_e = SrcaShamt; end
          FnSra:  begin op_e = AluSra; srca_e = SrcaShamt; end
          FnSllv: begin op_e = AluSll; srca_e = SrcaRsLow; end
          FnSrlv: begin op_e = AluSrl; srca_e = SrcaRsLow; end
          FnSrav: begin op_e = AluSra; srca_e = SrcaRsLow; end
          default: cls_e = ClsIllegal;
        endcase
      end
      OpAddiu: begin cls_e = ClsAluI; op_e = AluAdd;  srcb_e = SrcbImmSext; end
      OpSlti:  begin cls_e = ClsAluI; op_e = AluSlt;  srcb_e = SrcbImmSext; end
      OpSltiu: begin cls_e = ClsAluI; op_e = AluSltu; srcb_e = SrcbImmSext; end
      OpAndi:  begin cls_e = ClsAluI; op_e = AluAnd;  srcb_e = SrcbImmZext; end
      OpOri:   begin cls_e = ClsAluI; op_e = AluOr;   srcb_e = SrcbImmZext; end
      OpXori:  begin cls_e = ClsAluI; op_e = AluXor;  srcb_e = SrcbImmZext; end
      OpBeq:   begin cls_e = ClsBranch; op_e = AluEq; end
      OpBne:   begin cls_e = ClsBranch; op_e = AluEq; br_invert = 1'b1; end
      OpBlez:  begin cls_e = ClsBranch; op_e = AluLez; end
      OpBgtz:  begin cls_e = ClsBranch; op_e = AluLez; br_invert = 1'b1; end
      OpRegimm: begin
        if (rt == RtBltz) begin
          cls_e = ClsBranch;
          op_e  = AluLtz;
        end else if (rt == RtBgez) begin
          cls_e     = ClsBranch;
          op_e      = AluLtz;
          br_invert = 1'b1;
        end
      end
      default: cls_e = ClsIllegal;
    endcase
  end

  assign cls     = cls_e;
  assign op      = op_e;
  assign srca    = srca_e;
  assign srcb    = srcb_e;
  assign reg_dst = (cls_e == ClsAluR);

endmodule

// File: rtl/exec_ctrl.sv
// Multicycle execute controller: accepts one MIPS instruction at a time and
// sequences ALU, writeback and branch-target strobes through a small FSM.
module exec_ctrl
  import exec_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] alu_result,
  output logic [4:0]  alu_control,
  output logic [1:0]  srca_sel,
  output logic [1:0]  srcb_sel,
  output logic        alu_out_en,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        pc_write,
  output logic        done,
  output logic        illegal
);

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic        taken_q, taken_d;
  logic        illegal_q, illegal_d;

  logic [1:0]  dec_cls;
  logic [4:0]  dec_op;
  logic [1:0]  dec_srca;
  logic [1:0]  dec_srcb;
  logic        dec_reg_dst;
  logic        dec_br_invert;
  logic        br_taken;

  // Only bit 0 carries the comparison outcome
  logic unused_alu;
  assign unused_alu = ^alu_result[31:1];

  exec_decode u_decode (
    .ir        (ir_q),
    .cls       (dec_cls),
    .op        (dec_op),
    .srca      (dec_srca),
    .srcb      (dec_srcb),
    .reg_dst   (dec_reg_dst),
    .br_invert (dec_br_invert)
  );

  assign br_taken = alu_result[0] ^ dec_br_invert;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      ir_q      <= '0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    taken_d     = taken_q;
    illegal_d   = illegal_q;

    instr_ready = 1'b0;
    alu_control = AluAnd;
    srca_sel    = SrcaRs;
    srcb_sel    = SrcbRt;
    alu_out_en  = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    pc_write    = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;

    unique case (state_q)
      StIdle: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          ir_d      = instr;
          illegal_d = 1'b0;
          taken_d   = 1'b0;
          state_d   = StDecode;
        end
      end
      StDecode: begin
        if (dec_cls == ClsAluR || dec_cls == ClsAluI) begin
          state_d = StExec;
        end else if (dec_cls == ClsBranch) begin
          state_d = StBrCmp;
        end else begin
          illegal_d = 1'b1;
          state_d   = StDone;
        end
      end
      StExec: begin
        alu_control = dec_op;
        srca_sel    = dec_srca;
        srcb_sel    = dec_srcb;
        alu_out_en  = 1'b1;
        reg_dst     = dec_reg_dst;
        state_d     = StWb;
      end
      StWb: begin
        reg_write = 1'b1;
        reg_dst   = dec_reg_dst;
        state_d   = StDone;
      end
      StBrCmp: begin
        alu_control = dec_op;
        srca_sel    = dec_srca;
        srcb_sel    = dec_srcb;
        taken_d     = br_taken;
        state_d     = br_taken ? StBrTgt : StDone;
      end
      StBrTgt: begin
        // Target = PC + (sext(imm) << 2)
        alu_control = AluAdd;
        srca_sel    = SrcaPc;
        srcb_sel    = SrcbImmSext2;
        pc_write    = taken_q;
        state_d     = StDone;
      end
      StDone: begin
        done    = 1'b1;
        illegal = illegal_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl: steps each instruction class cycle by cycle and
// compares the full output bundle against hand-computed values.
module tb_exec_ctrl;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] alu_result;
  logic [4:0]  alu_control;
  logic [1:0]  srca_sel;
  logic [1:0]  srcb_sel;
  logic        alu_out_en;
  logic        reg_write;
  logic        reg_dst;
  logic        pc_write;
  logic        done;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  exec_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_result  (alu_result),
    .alu_control (alu_control),
    .srca_sel    (srca_sel),
    .srcb_sel    (srcb_sel),
    .alu_out_en  (alu_out_en),
    .reg_write   (reg_write),
    .reg_dst     (reg_dst),
    .pc_write    (pc_write),
    .done        (done),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bundle: {op[4:0], srca[1:0], srcb[1:0], aoe, rw, rd, pw, done, ill, rdy}
  function automatic logic [15:0] obs();
    return {alu_control, srca_sel, srcb_sel, alu_out_en, reg_write, reg_dst,
            pc_write, done, illegal, instr_ready};
  endfunction

  function automatic logic [15:0] ev(input logic [4:0] op, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic aoe,
                                     input logic rw, input logic rd, input logic pw,
                                     input logic dn, input logic il, input logic rdy);
    return {op, sa, sb, aoe, rw, rd, pw, dn, il, rdy};
  endfunction

  localparam logic [15:0] Idle = 16'h0001;
  localparam logic [15:0] Busy = 16'h0000;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Called at a negedge while idle; hold keeps instr_valid high (with a junk word)
  // through the busy cycles to show nothing extra is accepted.
  task automatic run_alu(input string name, input logic [31:0] ins, input logic [4:0] op,
                         input logic [1:0] sa, input logic [1:0] sb, input logic rd,
                         input logic hold);
    instr = ins;
    instr_valid = 1'b1;
    check({name, "_accept"}, obs(), Idle);
    @(negedge clk);
    if (hold) instr = 32'hFC00_0000;
    else instr_valid = 1'b0;
    check({name, "_decode"}, obs(), Busy);
    @(negedge clk);
    check({name, "_exec"}, obs(), ev(op, sa, sb, 1'b1, 1'b0, rd, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    check({name, "_wb"}, obs(), ev(5'b0, 2'b0, 2'b0, 1'b0, 1'b1, rd, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    check({name, "_done"}, obs(), ev(5'b0, 2'b0, 2'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                     1'b0));
    instr_valid = 1'b0;
    @(negedge clk);
    check({name, "_idle"}, obs(), Idle);
  endtask

  task automatic run_br(input string name, input logic [31:0] ins, input logic [4:0] op,
                        input logic res, input logic taken);
    instr = ins;
    instr_valid = 1'b1;
    check({name, "_accept"}, obs(), Idle);
    @(negedge clk);
    instr_valid = 1'b0;
    alu_result = {31'h1234_5678, res};
    check({name, "_decode"}, obs(), Busy);
    @(negedge clk);
    check({name, "_cmp"}, obs(), ev(op, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                    1'b0));
    @(negedge clk);
    alu_result = '0;
    if (taken) begin
      check({name, "_tgt"}, obs(), ev(5'b00010, 2'b01, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                      1'b0, 1'b0));
      @(negedge clk);
    end
    check({name, "_done"}, obs(), ev(5'b0, 2'b0, 2'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                     1'b0));
    @(negedge clk);
    check({name, "_idle"}, obs(), Idle);
  endtask

  task automatic run_ill(input string name, input logic [31:0] ins);
    instr = ins;
    instr_valid = 1'b1;
    check({name, "_accept"}, obs(), Idle);
    @(negedge clk);
    instr_valid = 1'b0;
    check({name, "_decode"}, obs(), Busy);
    @(negedge clk);
    check({name, "_done"}, obs(), ev(5'b0, 2'b0, 2'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                                     1'b0));
    @(negedge clk);
    check({name, "_idle"}, obs(), Idle);
  endtask

  initial begin
    reset = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    alu_result = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_hold", obs(), Idle);
    reset = 1'b0;
    @(negedge clk);
    check("reset_idle", obs(), Idle);

    run_alu("addu",  32'h0085_1021, 5'b00010, 2'b00, 2'b00, 1'b1, 1'b0);
    run_alu("subu",  32'h0085_1023, 5'b00110, 2'b00, 2'b00, 1'b1, 1'b0);
    run_alu("slt",   32'h0085_102A, 5'b00111, 2'b00, 2'b00, 1'b1, 1'b0);
    run_alu("sll",   32'h0005_1100, 5'b00100, 2'b10, 2'b00, 1'b1, 1'b0);
    run_alu("sra",   32'h0005_1103, 5'b01000, 2'b10, 2'b00, 1'b1, 1'b0);
    run_alu("srav",  32'h0085_1007, 5'b01000, 2'b11, 2'b00, 1'b1, 1'b0);
    run_alu("ori",   32'h3485_1234, 5'b00001, 2'b00, 2'b10, 1'b0, 1'b0);
    run_alu("addiu", 32'h2485_1234, 5'b00010, 2'b00, 2'b01, 1'b0, 1'b0);
    run_alu("sltiu", 32'h2C85_1234, 5'b01001, 2'b00, 2'b01, 1'b0, 1'b0);
    run_alu("busy_valid", 32'h0085_1021, 5'b00010, 2'b00, 2'b00, 1'b1, 1'b1);

    run_br("beq_t",  32'h1085_0004, 5'b01010, 1'b1, 1'b1);
    run_br("beq_n",  32'h1085_0004, 5'b01010, 1'b0, 1'b0);
    run_br("bne_n",  32'h1485_0004, 5'b01010, 1'b1, 1'b0);
    run_br("bne_t",  32'h1485_0004, 5'b01010, 1'b0, 1'b1);
    run_br("bgtz_t", 32'h1C80_0004, 5'b10000, 1'b0, 1'b1);
    run_br("blez_t", 32'h1880_0004, 5'b10000, 1'b1, 1'b1);
    run_br("bltz_t", 32'h0480_0004, 5'b01100, 1'b1, 1'b1);
    run_br("bgez_n", 32'h0481_0004, 5'b01100, 1'b1, 1'b0);

    run_ill("ill_op3f",   32'hFC00_0000);
    run_ill("ill_funct",  32'h0085_1001);
    run_ill("ill_regimm", 32'h0482_0004);
    // Illegal flag must not leak into the following instruction
    run_alu("after_ill", 32'h0085_1025, 5'b00001, 2'b00, 2'b00, 1'b1, 1'b0);

    // Reset while in WB
    instr = 32'h0085_1021;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_wb_pre", obs(), ev(5'b0, 2'b0, 2'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    reset = 1'b1;
    @(negedge clk);
    check("rst_wb_idle", obs(), Idle);
    reset = 1'b0;
    @(negedge clk);
    check("rst_wb_stay", obs(), Idle);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
